tick_debounce_gen: RTL and testbench
====================================

TICK_DEBOUNCE_GEN -- requirements
Module: tick_debounce_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive synchronized-stable cycles required to accept a press or release; legal range 1..1023.
REQ-002 Parameter RPT_DELAY, default 20: cycles from first tick to first auto-repeat tick; legal range 1..65535.
REQ-003 Parameter RPT_PERIOD, default 8: cycles between auto-repeat ticks; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  1  raw asynchronous, bouncing button level; 1 = pressed.
REQ-007 rpt_en  input  1  auto-repeat enable, synchronous to clk.
REQ-008 tick  output  1  registered one-cycle count-enable pulse for the downstream 3-bit T-counter.
REQ-009 btn_level  output  1  registered debounced button level.
REQ-010 rpt_active  output  1  registered; 1 while in REPEAT state.

Function
REQ-011 btn_in shall pass through a 2-flop synchronizer; btn_s is the second-flop output, 2 cycles behind btn_in.
REQ-012 FSM states: IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE.
REQ-013 IDLE: btn_s=1 -> DB_PRESS, stable counter cleared.
REQ-014 DB_PRESS: btn_s=0 -> IDLE, no tick; btn_s=1 for DB_CYCLES consecutive cycles -> HELD, btn_level=1, tick=1 for exactly one cycle.
REQ-015 Press latency: btn_in first sampled 1 at edge e0 and held -> tick high in the cycle after edge e0+DB_CYCLES+2.
REQ-016 HELD: repeat counter counts cycles since entry; at RPT_DELAY with rpt_en=1 -> REPEAT, one tick; with rpt_en=0 stays HELD, counter saturates, no tick.
REQ-017 REPEAT: one tick every RPT_PERIOD cycles; rpt_en=0 -> HELD with repeat counter cleared, no further ticks.
REQ-018 HELD or REPEAT with btn_s=0 -> DB_RELEASE; no tick on that edge.
REQ-019 DB_RELEASE: btn_s=0 for DB_CYCLES consecutive cycles -> IDLE, btn_level=0; btn_s=1 earlier -> HELD, repeat counter cleared, no tick.
REQ-020 tick shall never be high on two consecutive cycles unless RPT_PERIOD=1 in REPEAT.
REQ-021 Any btn_s change during DB_PRESS or DB_RELEASE restarts debouncing per REQ-014/019; bounces shorter than DB_CYCLES produce no tick and no btn_level change.
REQ-022 Counters sized $clog2(max parameter)+1 bits; no wrap: stable counter stops at DB_CYCLES, repeat counter saturates.

Reset
REQ-023 reset=1 at an edge: state IDLE, synchronizer flops 0, all counters 0, tick=0, btn_level=0, rpt_active=0 after that edge.
REQ-024 Reset overrides every other condition, including a tick due on the same edge.
REQ-025 After reset release with btn_in already high, a full press debounce (REQ-015 latency measured from first post-reset edge) is required before any tick.

Structure
REQ-026 Shared package tick_debounce_pkg holds the state enum and the default DB_CYCLES, RPT_DELAY, RPT_PERIOD constants.
REQ-027 Synchronizer is a separate sub-module sync_2ff (clk, reset, d, q); FSM and counters stay in tick_debounce_gen.
REQ-028 Illegal parameter values shall fail elaboration.

Verification
REQ-029 Clean press, defaults, rpt_en=0: btn_in 0->1 at edge 0, held 60 cycles -> single tick in cycle after edge 6, btn_level=1 from edge 6, no further ticks.
REQ-030 Bounce: btn_in toggles every 2 cycles for 20 cycles then stays 1 -> no tick during bounce; exactly one tick DB_CYCLES+2 cycles after last rise.
REQ-031 Auto-repeat, rpt_en=1, held 50 cycles -> ticks after edges 6, 26, 34, 42; rpt_active=1 from edge 26; tick count matches.
REQ-032 Release glitch: in HELD, btn_in low 2 cycles then high -> returns to HELD, no tick, btn_level stays 1, repeat delay restarts.
REQ-033 Reset mid-REPEAT: reset high 1 cycle -> all outputs 0 next edge; btn_in still high -> next tick exactly DB_CYCLES+2 cycles after reset release.
REQ-034 Integration: tick drives t_counter_3bit count enable; 9 presses -> counter wraps to 1.

Source files
------------

// File: rtl/tick_debounce_pkg.sv
// Shared definitions for the button debounce / tick generator: FSM state
// encoding, default timing constants and legal parameter limits.
package tick_debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_DB_RELEASE = 3'd4
    } state_e;

    localparam int unsigned DEF_DB_CYCLES  = 4;
    localparam int unsigned DEF_RPT_DELAY  = 20;
    localparam int unsigned DEF_RPT_PERIOD = 8;

    localparam int unsigned MAX_DB_CYCLES  = 1023;
    localparam int unsigned MAX_RPT_CYCLES = 65535;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tick_debounce_gen.sv
// Debounces a bouncing push button and turns accepted presses (plus optional
// auto-repeat while held) into single-cycle count-enable ticks.
module tick_debounce_gen
    import tick_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
    parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
    parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic rpt_en,
    output logic tick,
    output logic btn_level,
    output logic rpt_active
);

    localparam int unsigned DB_W    = $clog2(DB_CYCLES) + 1;
    localparam int unsigned RPT_MAX = max_u(RPT_DELAY, RPT_PERIOD);
    localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

    // Terminal values: a count of N cycles completes when the counter,
    // cleared on entry, reads N-1 at an edge.
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);

    if ((DB_CYCLES < 1) || (DB_CYCLES > MAX_DB_CYCLES)) begin : g_bad_db_cycles
        $error("tick_debounce_gen: DB_CYCLES must be within 1..1023");
    end
    if ((RPT_DELAY < 1) || (RPT_DELAY > MAX_RPT_CYCLES)) begin : g_bad_rpt_delay
        $error("tick_debounce_gen: RPT_DELAY must be within 1..65535");
    end
    if ((RPT_PERIOD < 1) || (RPT_PERIOD > MAX_RPT_CYCLES)) begin : g_bad_rpt_period
        $error("tick_debounce_gen: RPT_PERIOD must be within 1..65535");
    end

    logic btn_s;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    state_e           state_q,      state_d;
    logic [DB_W-1:0]  db_cnt_q,     db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q,    rpt_cnt_d;
    logic             tick_q,       tick_d;
    logic             level_q,      level_d;
    logic             rpt_active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            db_cnt_q     <= '0;
            rpt_cnt_q    <= '0;
            tick_q       <= 1'b0;
            level_q      <= 1'b0;
            rpt_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            rpt_cnt_q    <= rpt_cnt_d;
            tick_q       <= tick_d;
            level_q      <= level_d;
            rpt_active_q <= (state_d == ST_REPEAT);
        end
    end

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        tick_d    = 1'b0;
        level_d   = level_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d  = ST_DB_PRESS;
                    db_cnt_d = '0;
                end
            end

            ST_DB_PRESS: begin
                if (!btn_s) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_HELD;
                    db_cnt_d  = '0;
                    rpt_cnt_d = '0;
                    level_d   = 1'b1;
                    tick_d    = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            ST_HELD: begin
                // Release has priority; the repeat counter parks at its
                // terminal value so a late rpt_en starts repeating at once.
                if (!btn_s) begin
                    state_d  = ST_DB_RELEASE;
                    db_cnt_d = '0;
                end else if (rpt_cnt_q >= DELAY_LAST) begin
                    if (rpt_en) begin
                        state_d   = ST_REPEAT;
                        rpt_cnt_d = '0;
                        tick_d    = 1'b1;
                    end
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end

            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d  = ST_DB_RELEASE;
                    db_cnt_d = '0;
                end else if (!rpt_en) begin
                    state_d   = ST_HELD;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == PERIOD_LAST) begin
                    rpt_cnt_d = '0;
                    tick_d    = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end
            end

            ST_DB_RELEASE: begin
                if (btn_s) begin
                    state_d   = ST_HELD;
                    db_cnt_d  = '0;
                    rpt_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                    level_d  = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                db_cnt_d  = '0;
                rpt_cnt_d = '0;
                level_d   = 1'b0;
            end
        endcase
    end

    assign tick       = tick_q;
    assign btn_level  = level_q;
    assign rpt_active = rpt_active_q;

endmodule

// File: tb/tb_tick_debounce_gen.sv
// Randomized and directed bench for tick_debounce_gen against a run-length
// reference model of the debounce / auto-repeat rules.
module tb_tick_debounce_gen;

    localparam int DB     = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic rpt_en;
    logic tick;
    logic btn_level;
    logic rpt_active;

    tick_debounce_gen #(
        .DB_CYCLES  (DB),
        .RPT_DELAY  (DELAY),
        .RPT_PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .rpt_en     (rpt_en),
        .tick       (tick),
        .btn_level  (btn_level),
        .rpt_active (rpt_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;
    int tick_q[$];
    int exp_q[$];
    logic [2:0] t_cnt = 3'd0;
    logic prev_tick = 1'b0;

    // Reference model: synchronizer history plus run lengths of the synced level.
    bit m_s1, m_s2;
    bit m_level, m_rep, m_tick;
    int m_ones, m_zeros, m_held_age, m_since;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit s;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_rep = 0; m_tick = 0;
            m_ones = 0; m_zeros = 0; m_held_age = 0; m_since = 0;
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_tick = 0;
            if (!m_level) begin
                m_ones = s ? m_ones + 1 : 0;
                if (m_ones == DB + 1) begin
                    m_level = 1; m_tick = 1; m_ones = 0;
                    m_zeros = 0; m_held_age = 0; m_rep = 0;
                end
            end else if (!s) begin
                m_rep = 0;
                m_zeros++;
                if (m_zeros == DB + 1) begin
                    m_level = 0; m_zeros = 0; m_ones = 0;
                end
            end else if (m_zeros != 0) begin
                m_zeros = 0; m_held_age = 0;
            end else if (!m_rep) begin
                if (m_held_age < DELAY) m_held_age++;
                if (m_held_age >= DELAY && rpt_en) begin
                    m_rep = 1; m_tick = 1; m_since = 0;
                end
            end else if (!rpt_en) begin
                m_rep = 0; m_held_age = 0;
            end else begin
                m_since++;
                if (m_since == PERIOD) begin
                    m_tick = 1; m_since = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_val("tick", {31'd0, tick}, {31'd0, m_tick});
        check_val("btn_level", {31'd0, btn_level}, {31'd0, m_level});
        check_val("rpt_active", {31'd0, rpt_active}, {31'd0, m_rep});
        check_val("no_double_tick", {31'd0, tick & prev_tick}, 32'd0);
        prev_tick = tick;
        if (tick === 1'b1) begin
            tick_q.push_back(cyc - base);
            t_cnt = t_cnt + 3'd1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_window();
        base = cyc + 1;
        tick_q.delete();
    endtask

    task automatic expect_edges(input string tag);
        check_val({tag, "_count"}, tick_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tick_q.size(); i++)
            check_val(tag, tick_q[i], exp_q[i]);
    endtask

    initial begin
        int len;
        int low_cnt;

        reset = 1'b1; btn_in = 1'b0; rpt_en = 1'b0;
        run(3);
        check_val("reset_tick", {31'd0, tick}, 32'd0);
        check_val("reset_level", {31'd0, btn_level}, 32'd0);
        check_val("reset_rpt_active", {31'd0, rpt_active}, 32'd0);
        reset = 1'b0;
        run(4);

        // Clean press, no auto-repeat.
        btn_in = 1'b1;
        start_window();
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 5) check_val("level_before_accept", {31'd0, btn_level}, 32'd0);
            if (i == 6) check_val("level_at_accept", {31'd0, btn_level}, 32'd1);
        end
        exp_q = {6};
        expect_edges("clean_press_edges");
        $display("scenario clean_press: ticks=%0d", tick_q.size());
        btn_in = 1'b0;
        run(20);

        // Bounce: toggle every 2 cycles for 20 cycles, then settle high.
        start_window();
        for (int i = 0; i < 60; i++) begin
            btn_in = (i >= 20) ? 1'b1 : (((i / 2) % 2) == 0);
            step();
        end
        exp_q = {26};
        expect_edges("bounce_edges");
        $display("scenario bounce: ticks=%0d", tick_q.size());
        btn_in = 1'b0;
        run(20);

        // Auto-repeat.
        rpt_en = 1'b1;
        btn_in = 1'b1;
        start_window();
        for (int i = 0; i < 50; i++) begin
            step();
            if (i == 25) check_val("rpt_active_before", {31'd0, rpt_active}, 32'd0);
            if (i == 26) check_val("rpt_active_at", {31'd0, rpt_active}, 32'd1);
        end
        exp_q = {6, 26, 34, 42};
        expect_edges("repeat_edges");
        $display("scenario auto_repeat: ticks=%0d", tick_q.size());
        btn_in = 1'b0;
        run(20);

        // Release glitch while held: repeat delay restarts.
        start_window();
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            btn_in = !(i == 10 || i == 11);
            step();
            if (i >= 6 && btn_level !== 1'b1) low_cnt++;
        end
        exp_q = {6, 34};
        expect_edges("glitch_edges");
        check_val("glitch_level_drops", low_cnt, 32'd0);
        $display("scenario release_glitch: ticks=%0d", tick_q.size());
        btn_in = 1'b0;
        run(20);

        // Reset in the middle of repeating with the button still held.
        btn_in = 1'b1;
        run(40);
        reset = 1'b1;
        step();
        check_val("midreset_tick", {31'd0, tick}, 32'd0);
        check_val("midreset_level", {31'd0, btn_level}, 32'd0);
        check_val("midreset_rpt_active", {31'd0, rpt_active}, 32'd0);
        reset = 1'b0;
        start_window();
        run(20);
        exp_q = {6};
        expect_edges("post_reset_edges");
        $display("scenario reset_mid_repeat: ticks=%0d", tick_q.size());
        btn_in = 1'b0;
        rpt_en = 1'b0;
        run(20);

        // Nine presses into a 3-bit count-enabled counter.
        t_cnt = 3'd0;
        for (int p = 0; p < 9; p++) begin
            btn_in = 1'b1;
            run(12);
            btn_in = 1'b0;
            run(12);
        end
        check_val("t_counter_wrap", {29'd0, t_cnt}, 32'd1);
        $display("scenario t_counter: count=%0d", t_cnt);

        // Randomized segments with rpt_en changes and occasional reset.
        for (int seg = 0; seg < 400; seg++) begin
            btn_in = ~btn_in;
            rpt_en = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                              : int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                reset = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 15) == 0) rpt_en = ~rpt_en;
                step();
            end
            reset = 1'b0;
        end
        $display("scenario random: cycles=%0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
